// File: rtl/nabp_shifter_multilane.sv
// nabp_shifter_multilane
// Shifter controller for the NABP backprojection datapath. Sequences the
// line-buffer fill phase and the shift phase for NUM_LANES independent
// mapper / line-buffer lanes, each with its own fixed-point accumulator.
// After the shift phase a short drain holds off new work until the delayed
// PE enable and done pulses have left the output pipeline.

module nabp_shifter_multilane #(
    parameter int IMAGE_SIZE  = 128,
    parameter int FILL_DEPTH  = 96,
    parameter int NUM_LANES   = 2,
    parameter int ACCU_INT_W  = 8,
    parameter int ACCU_FRAC_W = 12,
    parameter int OUT_DELAY   = 2,
    parameter int LB_DELAY    = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          sc_fill_kick,
    input  logic                                          sc_shift_kick,
    input  logic                                          sc_abort,
    input  logic [NUM_LANES*(ACCU_INT_W+ACCU_FRAC_W)-1:0] sc_accu_base,
    input  logic [NUM_LANES*(ACCU_INT_W+ACCU_FRAC_W)-1:0] sc_accu_init,
    output logic                                          sc_fill_done,
    output logic                                          sc_shift_done,
    output logic                                          sc_busy,
    output logic                                          mp_kick,
    output logic                                          mp_done,
    output logic [NUM_LANES-1:0]                          mp_shift_en,
    output logic                                          lb_clear,
    output logic [NUM_LANES-1:0]                          lb_shift_en,
    output logic                                          sw_pe_en
);

    localparam int AW      = ACCU_INT_W + ACCU_FRAC_W;
    // The counter holds fill depth, shift length and drain length in turn.
    localparam int CNT_MAX = (IMAGE_SIZE > OUT_DELAY) ? IMAGE_SIZE : OUT_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_READY,
        ST_FILL,
        ST_FILL_DONE,
        ST_SHIFT,
        ST_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fill_adv;
    logic             pe_en_l;
    logic             fill_done_l;
    logic             shift_done_l;

    // Output delay line: bit 0 = PE enable, bit 1 = fill done, bit 2 = shift done.
    logic [OUT_DELAY-1:0][2:0] out_pipe_q, out_pipe_d;

    // Next-state and phase counter; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_READY: begin
                if (sc_fill_kick) begin
                    state_d = ST_FILL;
                    cnt_d   = CNT_W'(FILL_DEPTH);
                end
            end
            ST_FILL: begin
                if (cnt_q == '0) begin
                    state_d = ST_FILL_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FILL_DONE: begin
                cnt_d = CNT_W'(IMAGE_SIZE - 1);
                if (sc_shift_kick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(OUT_DELAY - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        endcase
        if (sc_abort) begin
            state_d = ST_READY;
            cnt_d   = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Undelayed sources; all of them are quiet during DRAIN.
    assign fill_adv     = (state_q == ST_FILL) && (state_d == ST_FILL);
    assign fill_done_l  = (state_q == ST_FILL) && (cnt_q == '0);
    assign shift_done_l = (state_q == ST_SHIFT) && (cnt_q == '0);
    assign pe_en_l      = (state_q == ST_SHIFT);

    assign mp_kick  = sc_fill_kick && (state_q == ST_READY) && !sc_abort;
    assign lb_clear = mp_kick;
    assign sc_busy  = (state_q != ST_READY);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [AW-1:0] accu_q, accu_d;
            logic [AW-1:0] accu_sum;
            logic [AW-1:0] base_l;
            logic [AW-1:0] init_l;
            logic          step;

            assign base_l   = sc_accu_base[gi*AW +: AW];
            assign init_l   = sc_accu_init[gi*AW +: AW];
            // Modulo-2^AW add; wrap-around is a legal integer-part change.
            assign accu_sum = accu_q + base_l;
            assign step     = (accu_sum[AW-1:ACCU_FRAC_W] != accu_q[AW-1:ACCU_FRAC_W]);

            // Accumulator tracks the init value while waiting, then steps during SHIFT.
            always_comb begin
                accu_d = accu_q;
                if (state_q == ST_FILL_DONE) begin
                    accu_d = init_l;
                end else if ((state_q == ST_SHIFT) && (cnt_q != '0)) begin
                    accu_d = accu_sum;
                end
            end

            // Per-lane accumulator register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    accu_q <= '0;
                end else begin
                    accu_q <= accu_d;
                end
            end

            assign mp_shift_en[gi] = fill_adv || ((state_q == ST_SHIFT) && step);
        end
    endgenerate

    // Output delay line shifts one stage per cycle; abort flushes it.
    always_comb begin
        out_pipe_d[0] = {shift_done_l, fill_done_l, pe_en_l};
        for (int k = 1; k < OUT_DELAY; k++) begin
            out_pipe_d[k] = out_pipe_q[k-1];
        end
        if (sc_abort) begin
            out_pipe_d = '0;
        end
    end

    // Output delay line registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pipe_q <= '0;
        end else begin
            out_pipe_q <= out_pipe_d;
        end
    end

    assign sw_pe_en      = out_pipe_q[OUT_DELAY-1][0];
    assign sc_fill_done  = out_pipe_q[OUT_DELAY-1][1];
    assign sc_shift_done = out_pipe_q[OUT_DELAY-1][2];
    assign mp_done       = sc_shift_done;

    generate
        if (LB_DELAY == 0) begin : g_lb_direct
            assign lb_shift_en = mp_shift_en;
        end else begin : g_lb_pipe
            logic [LB_DELAY-1:0][NUM_LANES-1:0] lb_pipe_q, lb_pipe_d;

            // Line-buffer shift delay line; abort flushes it.
            always_comb begin
                lb_pipe_d[0] = mp_shift_en;
                for (int k = 1; k < LB_DELAY; k++) begin
                    lb_pipe_d[k] = lb_pipe_q[k-1];
                end
                if (sc_abort) begin
                    lb_pipe_d = '0;
                end
            end

            // Line-buffer delay registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lb_pipe_q <= '0;
                end else begin
                    lb_pipe_q <= lb_pipe_d;
                end
            end

            assign lb_shift_en = lb_pipe_q[LB_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_nabp_shifter_multilane.sv
// Testbench for nabp_shifter_multilane: directed scenarios followed by random
// kicks/aborts/resets, all checked against a phase/duration reference model.

module tb_nabp_shifter_multilane;

    localparam int IMAGE_SIZE  = 8;
    localparam int FILL_DEPTH  = 5;
    localparam int NUM_LANES   = 2;
    localparam int ACCU_INT_W  = 4;
    localparam int ACCU_FRAC_W = 4;
    localparam int OUT_DELAY   = 2;
    localparam int LB_DELAY    = 1;
    localparam int AW          = ACCU_INT_W + ACCU_FRAC_W;
    localparam int BW          = NUM_LANES * AW;
    localparam int MODV        = 1 << AW;
    localparam int FDIV        = 1 << ACCU_FRAC_W;
    localparam int MAXC        = 8192;

    localparam int P_READY = 0;
    localparam int P_FILL  = 1;
    localparam int P_FDONE = 2;
    localparam int P_SHIFT = 3;
    localparam int P_DRAIN = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 fk = 1'b0;
    logic                 sk = 1'b0;
    logic                 ab = 1'b0;
    logic [BW-1:0]        base_v = '0;
    logic [BW-1:0]        init_v = '0;
    logic                 sc_fill_done;
    logic                 sc_shift_done;
    logic                 sc_busy;
    logic                 mp_kick;
    logic                 mp_done;
    logic [NUM_LANES-1:0] mp_shift_en;
    logic                 lb_clear;
    logic [NUM_LANES-1:0] lb_shift_en;
    logic                 sw_pe_en;

    nabp_shifter_multilane #(
        .IMAGE_SIZE (IMAGE_SIZE),
        .FILL_DEPTH (FILL_DEPTH),
        .NUM_LANES  (NUM_LANES),
        .ACCU_INT_W (ACCU_INT_W),
        .ACCU_FRAC_W(ACCU_FRAC_W),
        .OUT_DELAY  (OUT_DELAY),
        .LB_DELAY   (LB_DELAY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sc_fill_kick (fk),
        .sc_shift_kick(sk),
        .sc_abort     (ab),
        .sc_accu_base (base_v),
        .sc_accu_init (init_v),
        .sc_fill_done (sc_fill_done),
        .sc_shift_done(sc_shift_done),
        .sc_busy      (sc_busy),
        .mp_kick      (mp_kick),
        .mp_done      (mp_done),
        .mp_shift_en  (mp_shift_en),
        .lb_clear     (lb_clear),
        .lb_shift_en  (lb_shift_en),
        .sw_pe_en     (sw_pe_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current phase, cycles spent in it, and per-job values.
    int ph        = P_READY;
    int el        = 0;
    int cyc       = 0;
    int clear_cyc = -1;
    int job_base [NUM_LANES];
    int job_init [NUM_LANES];
    logic [2:0]           src_hist [MAXC];
    logic [NUM_LANES-1:0] mp_hist  [MAXC];
    int pulse_cnt [NUM_LANES];
    bit count_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Accumulator value after k steps of the current job, modulo 2^AW.
    function automatic int lane_acc(input int l, input int k);
        return (job_init[l] + k * job_base[l]) % MODV;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"},  32'(sc_busy),       32'd0);
        check_eq({tag, "_kick"},  32'(mp_kick),       32'd0);
        check_eq({tag, "_clr"},   32'(lb_clear),      32'd0);
        check_eq({tag, "_mpen"},  32'(mp_shift_en),   32'd0);
        check_eq({tag, "_lben"},  32'(lb_shift_en),   32'd0);
        check_eq({tag, "_pe"},    32'(sw_pe_en),      32'd0);
        check_eq({tag, "_fdone"}, 32'(sc_fill_done),  32'd0);
        check_eq({tag, "_sdone"}, 32'(sc_shift_done), 32'd0);
        check_eq({tag, "_mdone"}, 32'(mp_done),       32'd0);
    endtask

    // One clock cycle: entered and left just after a rising edge.
    task automatic run_cycle(input logic f, input logic s, input logic a);
        logic [NUM_LANES-1:0] mp_e;
        logic [NUM_LANES-1:0] lb_e;
        logic [2:0]           src;
        logic [2:0]           dly;
        logic                 kick_e;
        fk = f;
        sk = s;
        ab = a;
        kick_e = f && (ph == P_READY) && !a;
        mp_e = '0;
        if (ph == P_FILL && el < FILL_DEPTH && !a) mp_e = '1;
        if (ph == P_SHIFT) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                mp_e[l] = (lane_acc(l, el) / FDIV) != (lane_acc(l, el + 1) / FDIV);
            end
        end
        src = {(ph == P_SHIFT && el == IMAGE_SIZE - 1), (ph == P_FILL && el == FILL_DEPTH),
               (ph == P_SHIFT)};
        src_hist[cyc] = src;
        mp_hist[cyc]  = mp_e;
        dly  = '0;
        lb_e = '0;
        if (cyc - OUT_DELAY > clear_cyc) dly  = src_hist[cyc - OUT_DELAY];
        if (cyc - LB_DELAY  > clear_cyc) lb_e = mp_hist[cyc - LB_DELAY];

        @(negedge clk);
        check_eq("mp_kick",       32'(mp_kick),       32'(kick_e));
        check_eq("lb_clear",      32'(lb_clear),      32'(kick_e));
        check_eq("mp_shift_en",   32'(mp_shift_en),   32'(mp_e));
        check_eq("lb_shift_en",   32'(lb_shift_en),   32'(lb_e));
        check_eq("sw_pe_en",      32'(sw_pe_en),      32'(dly[0]));
        check_eq("sc_fill_done",  32'(sc_fill_done),  32'(dly[1]));
        check_eq("sc_shift_done", 32'(sc_shift_done), 32'(dly[2]));
        check_eq("mp_done",       32'(mp_done),       32'(dly[2]));
        check_eq("sc_busy",       32'(sc_busy),       32'(ph != P_READY));
        if (count_en && ph == P_SHIFT) begin
            for (int l = 0; l < NUM_LANES; l++) pulse_cnt[l] += int'(mp_shift_en[l]);
        end

        if (a) begin
            if (ph != P_READY) $display("cyc %0d: abort from phase %0d", cyc, ph);
            ph = P_READY;
            el = 0;
            clear_cyc = cyc;
        end else begin
            case (ph)
                P_READY: if (f) begin
                    ph = P_FILL;
                    el = 0;
                    $display("cyc %0d: fill kick accepted", cyc);
                end
                P_FILL: if (el == FILL_DEPTH) begin ph = P_FDONE; el = 0; end else el++;
                P_FDONE: begin
                    for (int l = 0; l < NUM_LANES; l++) job_init[l] = int'(init_v[l*AW +: AW]);
                    if (s) begin
                        for (int l = 0; l < NUM_LANES; l++) job_base[l] = int'(base_v[l*AW +: AW]);
                        ph = P_SHIFT;
                        el = 0;
                        $display("cyc %0d: shift kick base=%h init=%h", cyc, base_v, init_v);
                    end
                end
                P_SHIFT: if (el == IMAGE_SIZE - 1) begin ph = P_DRAIN; el = 0; end else el++;
                P_DRAIN: if (el == OUT_DELAY - 1) begin
                    ph = P_READY;
                    el = 0;
                    $display("cyc %0d: drain complete", cyc);
                end else el++;
                default: ph = P_READY;
            endcase
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_until(input int target, input int budget);
        for (int i = 0; i < budget && ph != target; i++) run_cycle(1'b0, 1'b0, 1'b0);
        if (ph != target) check_eq("phase_timeout", 32'(ph), 32'(target));
    endtask

    // Reset asserted mid-cycle; outputs must fall before the next edge.
    task automatic async_reset_mid();
        fk = 1'b0;
        sk = 1'b0;
        ab = 1'b0;
        #2 reset = 1'b1;
        #1 check_idle("async_rst");
        $display("cyc %0d: async reset", cyc);
        @(posedge clk);
        #1 reset = 1'b0;
        ph = P_READY;
        el = 0;
        clear_cyc = cyc;
        cyc++;
    endtask

    task automatic fill_then_shift();
        run_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0);
        idle_until(P_DRAIN, 20);
    endtask

    initial begin
        for (int l = 0; l < NUM_LANES; l++) begin
            job_base[l]  = 0;
            job_init[l]  = 0;
            pulse_cnt[l] = 0;
        end
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        reset = 1'b0;

        // Fill then shift with base lane1=0x08, lane0=0x10, init 0.
        base_v = {8'h08, 8'h10};
        init_v = '0;
        count_en = 1'b1;
        fill_then_shift();
        count_en = 1'b0;
        check_eq("lane0_pulses", 32'(pulse_cnt[0]), 32'd8);
        check_eq("lane1_pulses", 32'(pulse_cnt[1]), 32'd4);
        // Fill kicks held through DRAIN are ignored; first READY cycle accepts.
        for (int i = 0; i < 10 && ph != P_READY; i++) run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0);

        // Wrap-around on lane 0, then abort on SHIFT cycle 3.
        init_v = {8'h7C, 8'hF8};
        base_v = {8'h03, 8'h10};
        idle_until(P_FDONE, 20);
        run_cycle(1'b0, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 1'b0);

        // Shift kick in READY, fill kick together with abort.
        run_cycle(1'b0, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0);

        // Async reset mid-FILL, then the first scenario again.
        run_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0);
        async_reset_mid();
        base_v = {8'h08, 8'h10};
        init_v = '0;
        fill_then_shift();
        idle_until(P_READY, 10);

        // Random kicks, aborts, parameters and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if (ph == P_READY && $urandom_range(0, 3) == 0) begin
                base_v = BW'($urandom);
                init_v = BW'($urandom);
            end
            if ($urandom_range(0, 399) == 0) begin
                async_reset_mid();
            end else begin
                run_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 59) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nabp_shifter_multilane.md
Name: nabp_shifter_multilane

Overview:
- Parametrised next-generation shifter controller for the NABP backprojection datapath.
- Sequences the line-buffer fill and shift phases for NUM_LANES independent filter-mapper/line-buffer lanes, each with its own fixed-point shift accumulator.
- Adds capabilities the single-lane shifter lacks: per-lane shift enables, a per-lane initial accumulator, a synchronous abort, a busy flag, and a drain phase that holds off new work until delayed outputs have flushed.
- Sits between state control (upstream) and the mappers, line buffers and PE switch (downstream).

Parameters:
- IMAGE_SIZE, 128, pixels per line; shift phase length in cycles.
- FILL_DEPTH, 96, position of the last PE tap; fill shift count. Must satisfy 1 ≤ FILL_DEPTH ≤ IMAGE_SIZE−1.
- NUM_LANES, 2, number of independent lanes.
- ACCU_INT_W, 8, accumulator integer bits.
- ACCU_FRAC_W, 12, accumulator fraction bits. AW = ACCU_INT_W + ACCU_FRAC_W.
- OUT_DELAY, 2, delay in cycles applied to sw_pe_en, sc_fill_done and sc_shift_done. Must be ≥ 1.
- LB_DELAY, 1, delay in cycles from mp_shift_en to lb_shift_en.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- sc_fill_kick  in  1  start fill phase.
- sc_shift_kick  in  1  start shift phase.
- sc_abort  in  1  synchronous abort.
- sc_accu_base  in  NUM_LANES*AW  per-lane increment; lane i occupies [i*AW +: AW].
- sc_accu_init  in  NUM_LANES*AW  per-lane initial accumulator value.
- sc_fill_done  out  1  fill complete, delayed pulse.
- sc_shift_done  out  1  shift complete, delayed pulse.
- sc_busy  out  1  high whenever state ≠ READY.
- mp_kick  out  1  mapper start.
- mp_done  out  1  mapper done; equals sc_shift_done.
- mp_shift_en  out  NUM_LANES  per-lane mapper advance.
- lb_clear  out  1  line-buffer clear; equals mp_kick.
- lb_shift_en  out  NUM_LANES  per-lane line-buffer shift.
- sw_pe_en  out  1  PE enable.

Behaviour:
- Reset: all outputs 0, state READY, cnt 0, accumulators 0, all delay pipelines 0.
- States and transitions:
  - READY → FILL on sc_fill_kick.
  - FILL → FILL_DONE when cnt == 0.
  - FILL_DONE → SHIFT on sc_shift_kick.
  - SHIFT → DRAIN when cnt == 0.
  - DRAIN → READY after OUT_DELAY cycles.
- Kicks are honoured only in the states listed above and ignored elsewhere.
- mp_kick = lb_clear = sc_fill_kick & (state == READY) & !sc_abort. Combinational, same cycle as the kick.
- FILL:
  - cnt is loaded with FILL_DEPTH on entry and decrements each cycle down to 0.
  - mp_shift_en is all-ones while in FILL and next_state == FILL, i.e. exactly FILL_DEPTH cycles.
  - fill_done_l = (state == FILL) & (cnt == 0).
- FILL_DONE:
  - cnt ← IMAGE_SIZE−1.
  - accu[i] ← sc_accu_init[i] every cycle; the value present on the cycle before SHIFT is the one used.
- SHIFT:
  - Lasts IMAGE_SIZE cycles.
  - accu_next[i] = accu[i] + base[i], computed modulo 2^AW; wrap-around is legal.
  - mp_shift_en[i] = floor(accu_next[i]) ≠ floor(accu[i]), comparing bits [AW−1:ACCU_FRAC_W].
  - accu[i] and cnt update only while cnt ≠ 0.
  - shift_done_l = (state == SHIFT) & (cnt == 0).
  - pe_en_l = (state == SHIFT).
- Delays:
  - sw_pe_en, sc_fill_done and sc_shift_done are the OUT_DELAY-cycle delays of pe_en_l, fill_done_l and shift_done_l.
  - lb_shift_en is the LB_DELAY-cycle delay of mp_shift_en.
- DRAIN: all *_l sources are 0; sc_busy stays high; sc_fill_kick is ignored.
- Abort:
  - sc_abort in any state forces next state READY and zeroes all delay pipelines on the next edge.
  - No done pulse emerges after an abort.
  - Abort takes priority over any simultaneous kick.
- Async reset mid-operation: outputs drop to 0 immediately; a new fill kick is accepted on the first cycle after reset deasserts.

Test Plan (IMAGE_SIZE=8, FILL_DEPTH=5, NUM_LANES=2, ACCU_INT_W=4, ACCU_FRAC_W=4, OUT_DELAY=2, LB_DELAY=1):
- Fill: sc_fill_kick at cycle 0 → mp_kick and lb_clear high at cycle 0; mp_shift_en = 2'b11 in cycles 1–5; lb_shift_en = 2'b11 in cycles 2–6; sc_fill_done is a single pulse at cycle 8.
- Shift: base = {0x08, 0x10}, init = 0, shift kick in FILL_DONE → over the 8 SHIFT cycles, lane 0 pulses 8 times and lane 1 pulses on SHIFT cycles 2, 4, 6 and 8; sw_pe_en is high for 8 cycles starting 2 cycles after SHIFT entry; sc_shift_done and mp_done pulse once, 2 cycles after the last SHIFT cycle; sc_busy falls after 2 DRAIN cycles.
- Wrap: lane 0 init 0xF8, base 0x10 → first SHIFT cycle has accu_next = 0x08 and mp_shift_en[0] = 1.
- Abort: sc_abort on SHIFT cycle 3 → READY on the next cycle; sw_pe_en and lb_shift_en are 0 from the next cycle; no sc_shift_done pulse; sc_busy = 0.
- Ignored kicks: sc_shift_kick in READY → no effect; sc_fill_kick during DRAIN → ignored; sc_fill_kick on the first READY cycle → accepted. sc_fill_kick and sc_abort together in READY → mp_kick = 0 and state stays READY.
- Async reset asserted mid-FILL → all outputs 0 within the same cycle; a subsequent fill repeats scenario 1 exactly.
